// File: rtl/musa_pkg.sv
// musa_pkg: shared redirect encodings, fetch FSM states and default widths
// for the musa fetch unit and its return-address stack.
package musa_pkg;

  localparam int PC_W_DEF    = 18;
  localparam int INSTR_W_DEF = 32;

  typedef enum logic [2:0] {
    REDIR_JMP  = 3'd0,
    REDIR_JPC  = 3'd1,
    REDIR_CALL = 3'd2,
    REDIR_RET  = 3'd3,
    REDIR_BRFL = 3'd4,
    REDIR_HALT = 3'd5
  } redir_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DROP,
    ST_HALTED
  } fetch_state_e;

endpackage

// File: rtl/musa_ras.sv
// musa_ras: circular return-address stack; a push when full silently
// overwrites the oldest entry, so only the newest DEPTH links survive.
module musa_ras #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] top
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] sp;
  logic [PTR_W:0]   count;

  always_ff @(posedge clk) begin
    if (push) mem[sp] <= push_data;
  end

  // sp points at the next free slot and wraps; count saturates at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp    <= '0;
      count <= '0;
    end else if (push) begin
      sp <= sp + 1'b1;
      if (!full) count <= count + 1'b1;
    end else if (pop && !empty) begin
      sp    <= sp - 1'b1;
      count <= count - 1'b1;
    end
  end

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);
  assign top   = mem[sp - 1'b1];

endmodule

// File: rtl/musa_fetch_unit.sv
// musa_fetch_unit: single-outstanding instruction fetch FSM with redirects.
// Define MUSA_FETCH_RAS_EN to build the return-address stack; otherwise CALL acts as JMP and RET halts.
module musa_fetch_unit
  import musa_pkg::*;
#(
  parameter int              PC_W      = PC_W_DEF,
  parameter int              INSTR_W   = INSTR_W_DEF,
  parameter int              RAS_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               instr_ready,
  input  logic               redir_valid,
  input  logic [2:0]         redir_kind,
  input  logic [PC_W-1:0]    redir_target,
  input  logic [PC_W-1:0]    redir_link,
  input  logic               redir_cond,
  output logic               halted,
  output logic               ras_overflow,
  output logic               ras_underflow
);

  fetch_state_e    state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] last_pc;
  logic [PC_W-1:0] redir_pc;
  logic [PC_W-1:0] ras_top;
  logic            ras_empty;
  logic            eff_redir;
  logic            ret_fail;
  logic            go_halt;
  logic            issue;
  logic            accept;

  always_comb begin
    eff_redir = 1'b0;
    redir_pc  = pc;
    if (redir_valid && state != ST_HALTED) begin
      case (redir_kind)
        REDIR_JMP, REDIR_CALL: begin
          eff_redir = 1'b1;
          redir_pc  = redir_target;
        end
        REDIR_JPC: begin
          eff_redir = 1'b1;
          redir_pc  = last_pc + redir_target;
        end
        REDIR_RET: begin
          eff_redir = 1'b1;
          redir_pc  = ras_top;
        end
        REDIR_BRFL: begin
          eff_redir = redir_cond;
          redir_pc  = redir_target;
        end
        REDIR_HALT: eff_redir = 1'b1;
        default: ;
      endcase
    end
  end

  assign ret_fail = eff_redir && (redir_kind == REDIR_RET) && ras_empty;
  assign go_halt  = eff_redir && ((redir_kind == REDIR_HALT) || ret_fail);
  assign accept   = instr_valid && instr_ready;
  // A redirect in IDLE wins over the issue so the next fetch uses the new pc
  assign issue    = (state == ST_IDLE) && fetch_en && (!instr_valid || instr_ready) && !eff_redir;

  assign imem_req  = rst_n && issue;
  assign imem_addr = pc;
  assign halted    = (state == ST_HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      pc            <= RESET_PC;
      last_pc       <= RESET_PC;
      instr_valid   <= 1'b0;
      instr         <= '0;
      instr_pc      <= '0;
      ras_underflow <= 1'b0;
    end else begin
      if (accept) instr_valid <= 1'b0;
      if (eff_redir) begin
        instr_valid <= 1'b0;
        if (go_halt) begin
          state <= ST_HALTED;
          if (ret_fail) ras_underflow <= 1'b1;
        end else begin
          pc <= redir_pc;
          if (state == ST_WAIT)                    state <= imem_valid ? ST_IDLE : ST_DROP;
          else if (state == ST_DROP && imem_valid) state <= ST_IDLE;
        end
      end else begin
        case (state)
          ST_IDLE: if (issue) begin
            last_pc <= pc;
            state   <= ST_WAIT;
          end
          ST_WAIT: if (imem_valid) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + 1'b1;
            state       <= ST_IDLE;
          end
          ST_DROP: if (imem_valid) state <= ST_IDLE;
          default: ;
        endcase
      end
    end
  end

`ifdef MUSA_FETCH_RAS_EN
  logic ras_push;
  logic ras_pop;
  logic ras_full;
  logic ovf;

  assign ras_push = eff_redir && (redir_kind == REDIR_CALL);
  assign ras_pop  = eff_redir && (redir_kind == REDIR_RET) && !ras_empty;

  musa_ras #(
    .WIDTH (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (redir_link),
    .full      (ras_full),
    .empty     (ras_empty),
    .top       (ras_top)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    ovf <= 1'b0;
    else if (ras_push && ras_full) ovf <= 1'b1;
  end

  assign ras_overflow = ovf;
`else
  // No stack: every RET sees an empty stack and the link is never stored
  logic unused_cfg;

  assign ras_empty    = 1'b1;
  assign ras_top      = '0;
  assign ras_overflow = 1'b0;
  assign unused_cfg   = ^redir_link ^ (RAS_DEPTH > 0);
`endif

endmodule

// File: doc/musa_fetch_unit.md
MUSA_FETCH_UNIT -- requirements
Module: musa_fetch_unit

Interface
REQ-001 The module SHALL have parameter PC_W, default 18, meaning program-counter and instruction-address width.
REQ-002 The module SHALL have parameter INSTR_W, default 32, meaning instruction word width.
REQ-003 The module SHALL have parameter RAS_DEPTH, default 8, meaning return-address-stack entries (power of 2, at least 2).
REQ-004 The module SHALL have parameter RESET_PC, default 0, meaning the PC value after reset.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-006 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The module SHALL have port fetch_en, input, 1 bit: permits issue of new fetches.
REQ-008 The module SHALL have port imem_req, output, 1 bit: one-cycle fetch request pulse.
REQ-009 The module SHALL have port imem_addr, output, PC_W bits: fetch address, valid with imem_req.
REQ-010 The module SHALL have port imem_valid, input, 1 bit, and port imem_rdata, input, INSTR_W bits: response strobe and data, arriving 1 or more cycles after imem_req.
REQ-011 The module SHALL have port instr_valid, output, 1 bit; port instr, output, INSTR_W bits; and port instr_pc, output, PC_W bits: the output register.
REQ-012 The module SHALL have port instr_ready, input, 1 bit: consumer accepts the output when both instr_valid and instr_ready are high.
REQ-013 The module SHALL have port redir_valid, input, 1 bit; port redir_kind, input, 3 bits; port redir_target, input, PC_W bits; port redir_link, input, PC_W bits; and port redir_cond, input, 1 bit: the redirect request.
REQ-014 The module SHALL have ports halted, ras_overflow and ras_underflow, each output, 1 bit, as status flags; ras_overflow and ras_underflow are sticky.

Function
REQ-015 redir_kind encodings SHALL be: JMP=0 (pc<=target); JPC=1 (pc<=pc_of_last_issue+target, modulo 2^PC_W); CALL=2 (push link, pc<=target); RET=3 (pc<=pop); BRFL=4 (pc<=target if cond, else no effect); HALT=5; values 6 and 7 are ignored.
REQ-016 The FSM SHALL have the states IDLE, WAIT, DROP and HALTED.
REQ-017 IDLE SHALL assert imem_req with imem_addr=pc and move to WAIT when fetch_en=1 and the output register is empty or is being accepted in the same cycle.
REQ-018 In WAIT, when imem_valid=1, the module SHALL load instr=imem_rdata, instr_pc=issued address and instr_valid=1, set pc<=issued address+1 (wrapping from 2^PC_W-1 to 0), and move to IDLE.
REQ-019 instr_valid, instr and instr_pc SHALL stay stable until accepted; acceptance without a new load SHALL clear instr_valid.
REQ-020 Throughput SHALL be one instruction per 2 cycles with single-cycle memory and continuous instr_ready.
REQ-021 An effective redirect SHALL clear instr_valid in the same edge and update pc.
REQ-022 An effective redirect in IDLE SHALL be followed by the next fetch at the new pc.
REQ-023 An effective redirect in WAIT with imem_valid=0 SHALL move the FSM to DROP.
REQ-024 An effective redirect in WAIT with imem_valid=1 SHALL discard the response and move to IDLE.
REQ-025 DROP SHALL discard the next imem_valid response and then move to IDLE; a further redirect while in DROP only updates pc.
REQ-026 A redirect SHALL take priority over an imem_valid load in the same cycle.
REQ-027 HALT SHALL enter HALTED from any state: halted=1, imem_req=0, instr_valid cleared, pending response ignored; only reset exits HALTED.
REQ-028 A CALL while the stack is full SHALL overwrite the oldest entry (circular) and set ras_overflow.
REQ-029 A RET while the stack is empty SHALL set ras_underflow and enter HALTED.
REQ-030 A redirect SHALL have no effect in HALTED.

Reset
REQ-031 While rst_n=0, the module SHALL asynchronously force: pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, halted=0, both RAS flags=0, RAS empty.
REQ-032 A reset mid-WAIT SHALL abandon the request; a late imem_valid after reset SHALL be ignored, since the FSM is in IDLE.

Configuration
REQ-033 With MUSA_FETCH_RAS_EN defined, the return-address stack SHALL be present as specified above.
REQ-034 Without MUSA_FETCH_RAS_EN, no stack storage SHALL exist: CALL behaves as JMP, RET sets ras_underflow and halts, and ras_overflow is tied to 0.

Structure
REQ-035 Package musa_pkg SHALL hold the redir_kind encodings, the FSM state enum and the default PC_W/INSTR_W.
REQ-036 Sub-module musa_ras SHALL be the parametrised RAS_DEPTH circular stack, with push, pop, full, empty and top.

Verification
REQ-037 Sequential: with reset, fetch_en=1, 1-cycle memory and instr_ready=1, the bench SHALL see imem_addr 0,1,2,3 and instr_pc 0,1,2,3 with matching data.
REQ-038 Backpressure: with instr_ready=0 for 5 cycles, the bench SHALL see instr/instr_pc held, exactly one outstanding fetch, and no lost or duplicated PC.
REQ-039 Redirect during WAIT: JMP target=0x100 while WAIT with a 3-cycle memory SHALL cause the old response to be dropped; the next instr_pc is 0x100.
REQ-040 CALL/RET: CALL target=0x40 link=0x11, then RET, SHALL fetch 0x40 and then 0x11; after RAS_DEPTH+1 nested CALLs, ras_overflow=1.
REQ-041 RET on an empty stack SHALL set ras_underflow=1 and halted=1 with no further imem_req.
REQ-042 Wrap and reset: RESET_PC=2^PC_W-1 SHALL fetch that address then 0; rst_n low mid-WAIT SHALL return all outputs to reset values immediately.
